operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 89 ++++++++
 tb/tb_operand_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Register file plus a one-entry valid/ready output stage that
//                presents an operand pair and shift code to the shifter/ALU.
//                Optional macro OPERAND_FETCH_BYPASS_EN forwards same-cycle
//                write data into the captured operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    input  logic [1:0]        shift_op_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [1:0]        shift_op_out
);

    localparam int         c_nregs    = 1 << ADDR_W;
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [DATA_W-1:0] r_regs [c_nregs];
    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [1:0]        r_op;

    logic              w_accept;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    assign out_valid    = (r_state == c_st_full);
    assign in_ready     = !out_valid || out_ready;
    assign w_accept     = in_valid && in_ready;
    assign a_out        = r_a;
    assign b_out        = r_b;
    assign shift_op_out = r_op;

`ifdef OPERAND_FETCH_BYPASS_EN
    // A write to the index being fetched is seen by the fetch in the same cycle.
    assign w_rd_a = (write && (writenum == readnum_a)) ? data_in : r_regs[readnum_a];
    assign w_rd_b = (write && (writenum == readnum_b)) ? data_in : r_regs[readnum_b];
`else
    assign w_rd_a = r_regs[readnum_a];
    assign w_rd_b = r_regs[readnum_b];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_nregs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (write) begin
            r_regs[writenum] <= data_in;
        end
    end

    // A new accept always overwrites the held pair; only a drain empties the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_empty;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 2'b00;
        end else if (w_accept) begin
            r_state <= c_st_full;
            r_a     <= w_rd_a;
            r_b     <= w_rd_b;
            r_op    <= shift_op_in;
        end else if (out_ready) begin
            r_state <= c_st_empty;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_fetch
//  Description : Directed self-checking bench for operand_fetch with a
//                behavioural register/slot model and per-cycle comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic [1:0]  shift_op_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [1:0]  shift_op_out;

    int errors = 0;
    int checks = 0;

    operand_fetch #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write        (write),
        .writenum     (writenum),
        .data_in      (data_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .readnum_a    (readnum_a),
        .readnum_b    (readnum_b),
        .shift_op_in  (shift_op_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .a_out        (a_out),
        .b_out        (b_out),
        .shift_op_out (shift_op_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: eight registers and a single holding slot.
    logic [15:0] m_regs [8];
    logic        m_valid;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [1:0]  m_op;
    logic        m_acc;

    assign m_acc = in_valid && (!m_valid || out_ready);

    function automatic logic [15:0] m_fetch(input logic [2:0] idx);
`ifdef OPERAND_FETCH_BYPASS_EN
        if (write && writenum == idx) return data_in;
`endif
        return m_regs[idx];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
            m_valid <= 1'b0;
            m_a     <= 16'h0000;
            m_b     <= 16'h0000;
            m_op    <= 2'b00;
        end else begin
            if (write) m_regs[writenum] <= data_in;
            if (m_acc) begin
                m_valid <= 1'b1;
                m_a     <= m_fetch(readnum_a);
                m_b     <= m_fetch(readnum_b);
                m_op    <= shift_op_in;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream shifter: 00 pass, 01 shift left, 10 logical right, 11 arithmetic right.
    function automatic logic [15:0] shifter(input logic [15:0] x, input logic [1:0] op);
        case (op)
            2'b00:   return x;
            2'b01:   return {x[14:0], 1'b0};
            2'b10:   return {1'b0, x[15:1]};
            default: return {x[15], x[15:1]};
        endcase
    endfunction

    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("a_out", {16'd0, a_out}, {16'd0, m_a});
            chk("b_out", {16'd0, b_out}, {16'd0, m_b});
            chk("shift_op_out", {30'd0, shift_op_out}, {30'd0, m_op});
        end
    end

    task automatic cyc(input logic wr, input logic [2:0] wn, input logic [15:0] din,
                       input logic iv, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [1:0] op, input logic ordy);
        write       = wr;
        writenum    = wn;
        data_in     = din;
        in_valid    = iv;
        readnum_a   = ra;
        readnum_b   = rb;
        shift_op_in = op;
        out_ready   = ordy;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] tbl [8];
    logic [15:0] exp_bypass_b;

    initial begin
        tbl[0] = 16'h0101; tbl[1] = 16'hA455; tbl[2] = 16'hFFFF; tbl[3] = 16'h1234;
        tbl[4] = 16'h4444; tbl[5] = 16'h5555; tbl[6] = 16'h6666; tbl[7] = 16'h7777;
`ifdef OPERAND_FETCH_BYPASS_EN
        exp_bypass_b = 16'h1234;
`else
        exp_bypass_b = 16'h0000;
`endif
        rst_n = 1'b1;
        write = 0; writenum = 0; data_in = 0; in_valid = 0;
        readnum_a = 0; readnum_b = 0; shift_op_in = 0; out_ready = 0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst a_out", {16'd0, a_out}, 32'd0);
        chk("rst b_out", {16'd0, b_out}, 32'd0);
        chk("rst shift_op", {30'd0, shift_op_out}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);

        // Write R1 then fetch A=B=R1.
        cyc(1, 3'd1, 16'hA455, 0, 0, 0, 2'b00, 0);
        cyc(0, 0, 0, 1, 3'd1, 3'd1, 2'b01, 0);
        chk("r1 out_valid", {31'd0, out_valid}, 32'd1);
        chk("r1 a_out", {16'd0, a_out}, 32'h0000A455);
        chk("r1 b_out", {16'd0, b_out}, 32'h0000A455);
        chk("r1 shift_op", {30'd0, shift_op_out}, 32'd1);

        // Hold R2 pair under backpressure while R2 is overwritten.
        cyc(1, 3'd2, 16'h2455, 0, 0, 0, 2'b00, 1);
        cyc(0, 0, 0, 1, 3'd0, 3'd2, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3'd2, 16'hFFFF, 1, 3'd1, 3'd1, 2'b11, 0);
            chk("hold b_out", {16'd0, b_out}, 32'h00002455);
            chk("hold in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold out_valid", {31'd0, out_valid}, 32'd1);
        end

        // Same-cycle write R3 and fetch B=R3.
        cyc(1, 3'd3, 16'h1234, 1, 3'd2, 3'd3, 2'b10, 1);
        chk("bypass out_valid", {31'd0, out_valid}, 32'd1);
        chk("bypass a_out", {16'd0, a_out}, 32'h0000FFFF);
        chk("bypass b_out", {16'd0, b_out}, {16'd0, exp_bypass_b});
        chk("bypass shift_op", {30'd0, shift_op_out}, 32'd2);
        if (exp_bypass_b == 16'h0000) cyc(1, 3'd3, 16'h1234, 0, 0, 0, 2'b00, 1);

        // Load the remaining registers, then stream eight back-to-back fetches.
        cyc(1, 3'd0, 16'h0101, 0, 0, 0, 2'b00, 1);
        for (int r = 4; r < 8; r++) cyc(1, 3'(r), tbl[r], 0, 0, 0, 2'b00, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 3'(i), 3'(7 - i), 2'(i), 1);
            chk("stream out_valid", {31'd0, out_valid}, 32'd1);
            chk("stream a_out", {16'd0, a_out}, {16'd0, tbl[i]});
            chk("stream b_out", {16'd0, b_out}, {16'd0, tbl[7 - i]});
        end
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 1);
        chk("drained out_valid", {31'd0, out_valid}, 32'd0);

        // Operand B into the shifter with arithmetic right shift.
        cyc(0, 0, 0, 1, 3'd0, 3'd1, 2'b11, 0);
        chk("shf b_out", {16'd0, b_out}, 32'h0000A455);
        chk("shf op", {30'd0, shift_op_out}, 32'd3);
        chk("shf asr", {16'd0, shifter(b_out, shift_op_out)}, 32'h0000D22A);
        chk("shf lsl", {16'd0, shifter(b_out, 2'b01)}, 32'h000048AA);
        chk("shf lsr", {16'd0, shifter(b_out, 2'b10)}, 32'h0000522A);

        // Asynchronous reset mid-cycle while holding a pair, spanning a write and request.
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst a_out", {16'd0, a_out}, 32'd0);
        chk("arst b_out", {16'd0, b_out}, 32'd0);
        chk("arst shift_op", {30'd0, shift_op_out}, 32'd0);
        write = 1; writenum = 3'd1; data_in = 16'hBEEF;
        in_valid = 1; readnum_a = 3'd1; readnum_b = 3'd1; out_ready = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("arst held out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 3'(i), 3'(i), 2'b00, 1);
            chk("cleared a_out", {16'd0, a_out}, 32'd0);
            chk("cleared b_out", {16'd0, b_out}, 32'd0);
        end
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
